// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-access pipeline stage.
// Accepts one instruction at a time from execute, optionally performs a single
// load/store on the data bus, and hands the result to writeback.
// Optional feature: define MAU_MISALIGN_CHK_EN to suppress misaligned halfword /
// word accesses and flag them with a one-cycle misalign_err pulse.
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              valid_last,
    output logic              ready_last,
    input  logic [31:0]       EX_result,
    input  logic [31:0]       rs2_value,
    input  logic [31:0]       rd_value,
    input  logic [2:0]        funct3,
    input  logic [4:0]        rd,
    input  logic              R_wen,
    input  logic              mem_wen,
    input  logic              mem_ren,
    input  logic              jump_flag,
    input  logic [31:0]       pc,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_wstrb,
    input  logic              dmem_ready,
    input  logic              dmem_rvalid,
    input  logic [31:0]       dmem_rdata,
    output logic              valid_next,
    input  logic              ready_next,
    output logic [31:0]       wb_value,
    output logic [4:0]        rd_next,
    output logic              R_wen_next,
    output logic [31:0]       pc_out,
    output logic              misalign_err
);

`ifdef MAU_MISALIGN_CHK_EN
    localparam bit MisalignChk = 1'b1;
`else
    localparam bit MisalignChk = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        OUT
    } state_t;

    state_t      state;
    logic [1:0]  lane;
    logic [2:0]  ld_funct3;
    logic        is_load;

    logic [1:0]  addr_lo;
    logic        is_mem;
    logic        misaligned;
    logic        suppress;
    logic [3:0]  st_strb;
    logic [31:0] st_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // Store lane placement and alignment check, computed from the incoming instruction
    always_comb begin
        addr_lo    = EX_result[1:0];
        is_mem     = mem_wen | mem_ren;
        st_strb    = 4'hF;
        st_data    = rs2_value;
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                st_strb = 4'b0001 << addr_lo;
                st_data = {4{rs2_value[7:0]}};
            end
            2'b01: begin
                st_strb    = 4'b0011 << {addr_lo[1], 1'b0};
                st_data    = {2{rs2_value[15:0]}};
                misaligned = addr_lo[0];
            end
            2'b10: begin
                misaligned = (addr_lo != 2'b00);
            end
            default: begin
                misaligned = 1'b0;
            end
        endcase
        suppress = MisalignChk & is_mem & misaligned;
    end

    // Load lane select and sign/zero extension using the latched address and size
    always_comb begin
        ld_byte = 8'(dmem_rdata >> {lane, 3'b000});
        ld_half = lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (ld_funct3[1:0])
            2'b00:   ld_ext = {{24{~ld_funct3[2] & ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = {{16{~ld_funct3[2] & ld_half[15]}}, ld_half};
            default: ld_ext = dmem_rdata;
        endcase
    end

    // Main control FSM; every output is a register updated here
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            ready_last   <= 1'b1;
            lane         <= 2'b00;
            ld_funct3    <= 3'b000;
            is_load      <= 1'b0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= 32'h0;
            dmem_wstrb   <= 4'h0;
            valid_next   <= 1'b0;
            wb_value     <= 32'h0;
            rd_next      <= 5'h0;
            R_wen_next   <= 1'b0;
            pc_out       <= 32'h0;
            misalign_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_last) begin
                        ready_last <= 1'b0;
                        rd_next    <= rd;
                        pc_out     <= pc;
                        lane       <= addr_lo;
                        ld_funct3  <= funct3;
                        is_load    <= mem_ren & ~mem_wen;
                        wb_value   <= jump_flag ? rd_value : EX_result;
                        R_wen_next <= R_wen & ~mem_wen;
                        if (suppress) begin
                            R_wen_next   <= 1'b0;
                            misalign_err <= 1'b1;
                            valid_next   <= 1'b1;
                            state        <= OUT;
                        end else if (is_mem) begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= mem_wen;
                            dmem_addr  <= {EX_result[ADDR_W-1:2], 2'b00};
                            dmem_wstrb <= mem_wen ? st_strb : 4'h0;
                            dmem_wdata <= mem_wen ? st_data : 32'h0;
                            state      <= REQ;
                        end else begin
                            valid_next <= 1'b1;
                            state      <= OUT;
                        end
                    end
                end
                REQ: begin
                    if (dmem_ready) begin
                        dmem_req <= 1'b0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (dmem_rvalid) begin
                        if (is_load) begin
                            wb_value <= ld_ext;
                        end
                        valid_next <= 1'b1;
                        state      <= OUT;
                    end
                end
                OUT: begin
                    misalign_err <= 1'b0;
                    if (ready_next) begin
                        valid_next <= 1'b0;
                        ready_last <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized self-checking bench for mem_access_unit.
// Expected results come from a small arithmetic model of load/store rules.
module tb_mem_access_unit;

`ifdef MAU_MISALIGN_CHK_EN
    localparam bit ChkEn = 1'b1;
`else
    localparam bit ChkEn = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        valid_last = 1'b0;
    logic        ready_last;
    logic [31:0] EX_result = 32'h0;
    logic [31:0] rs2_value = 32'h0;
    logic [31:0] rd_value = 32'h0;
    logic [2:0]  funct3 = 3'h0;
    logic [4:0]  rd = 5'h0;
    logic        R_wen = 1'b0;
    logic        mem_wen = 1'b0;
    logic        mem_ren = 1'b0;
    logic        jump_flag = 1'b0;
    logic [31:0] pc = 32'h0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = 32'h0;
    logic        valid_next;
    logic        ready_next = 1'b0;
    logic [31:0] wb_value;
    logic [4:0]  rd_next;
    logic        R_wen_next;
    logic [31:0] pc_out;
    logic        misalign_err;

    int checks = 0;
    int fails = 0;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clock(clock), .reset(reset),
        .valid_last(valid_last), .ready_last(ready_last),
        .EX_result(EX_result), .rs2_value(rs2_value), .rd_value(rd_value),
        .funct3(funct3), .rd(rd), .R_wen(R_wen), .mem_wen(mem_wen),
        .mem_ren(mem_ren), .jump_flag(jump_flag), .pc(pc),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .valid_next(valid_next), .ready_next(ready_next), .wb_value(wb_value),
        .rd_next(rd_next), .R_wen_next(R_wen_next), .pc_out(pc_out),
        .misalign_err(misalign_err)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Reference load result: pick the byte/half by address, extend by funct3[2]
    function automatic logic [31:0] expLoad(input logic [31:0] d, input logic [2:0] f3, input logic [1:0] a);
        int unsigned v;
        case (f3[1:0])
            2'd0: begin
                v = (d >> (8 * a)) % 256;
                if (!f3[2] && v >= 128) v = v + 32'hFFFFFF00;
            end
            2'd1: begin
                v = (d >> (16 * (a / 2))) % 65536;
                if (!f3[2] && v >= 32768) v = v + 32'hFFFF0000;
            end
            default: v = d;
        endcase
        return v;
    endfunction

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".ready_last"}, 32'(ready_last), 32'd1);
        checkOutput({tag, ".dmem_req"}, 32'(dmem_req), 32'd0);
        checkOutput({tag, ".dmem_we"}, 32'(dmem_we), 32'd0);
        checkOutput({tag, ".dmem_addr"}, dmem_addr, 32'd0);
        checkOutput({tag, ".dmem_wdata"}, dmem_wdata, 32'd0);
        checkOutput({tag, ".dmem_wstrb"}, 32'(dmem_wstrb), 32'd0);
        checkOutput({tag, ".valid_next"}, 32'(valid_next), 32'd0);
        checkOutput({tag, ".wb_value"}, wb_value, 32'd0);
        checkOutput({tag, ".rd_next"}, 32'(rd_next), 32'd0);
        checkOutput({tag, ".R_wen_next"}, 32'(R_wen_next), 32'd0);
        checkOutput({tag, ".pc_out"}, pc_out, 32'd0);
        checkOutput({tag, ".misalign_err"}, 32'(misalign_err), 32'd0);
    endtask

    task automatic scrambleInputs();
        EX_result = $urandom;
        rs2_value = $urandom;
        rd_value  = $urandom;
        funct3    = 3'($urandom);
        rd        = 5'($urandom);
        R_wen     = 1'($urandom);
        mem_wen   = 1'($urandom);
        mem_ren   = 1'($urandom);
        jump_flag = 1'($urandom);
        pc        = $urandom;
    endtask

    // One complete instruction: accept, optional bus access, writeback handshake.
    // Called and returns on a falling clock edge.
    task automatic applyStimulus(input string tag, input logic [31:0] ex, input logic [31:0] rs2,
                                 input logic [31:0] rdv, input logic [2:0] f3, input logic [4:0] rdi,
                                 input logic rw, input logic wen, input logic ren, input logic jmp,
                                 input logic [31:0] pcv, input logic [31:0] rdata,
                                 input int dlyReady, input int dlyRvalid, input int dlyNext);
        logic [1:0]  a;
        logic        isMem, isLoad, misal, expRw;
        logic [31:0] expWb, expAddr, expData;
        logic [3:0]  expStrb;
        a       = ex[1:0];
        isMem   = wen | ren;
        isLoad  = ren & ~wen;
        misal   = ChkEn && isMem && ((f3[1:0] == 2'd1 && a[0]) || (f3[1:0] == 2'd2 && a != 2'd0));
        expAddr = ex & 32'hFFFFFFFC;
        case (f3[1:0])
            2'd0: begin expStrb = 4'(1 << a); expData = (rs2 % 256) * 32'h01010101; end
            2'd1: begin expStrb = 4'(3 << (a & 2'd2)); expData = (rs2 % 65536) * 32'h00010001; end
            default: begin expStrb = 4'hF; expData = rs2; end
        endcase
        if (!wen) expStrb = 4'h0;
        expWb = isLoad ? expLoad(rdata, f3, a) : (jmp ? rdv : ex);
        expRw = rw & ~wen & ~misal;

        checkOutput({tag, ".idle_ready"}, 32'(ready_last), 32'd1);
        EX_result = ex; rs2_value = rs2; rd_value = rdv; funct3 = f3; rd = rdi;
        R_wen = rw; mem_wen = wen; mem_ren = ren; jump_flag = jmp; pc = pcv;
        valid_last = 1'b1;
        @(posedge clock);
        @(negedge clock);
        valid_last = 1'b0;
        scrambleInputs();

        if (isMem && !misal) begin
            for (int i = 0; i <= dlyReady; i++) begin
                checkOutput({tag, ".req"}, 32'(dmem_req), 32'd1);
                checkOutput({tag, ".we"}, 32'(dmem_we), 32'(wen));
                checkOutput({tag, ".addr"}, dmem_addr, expAddr);
                checkOutput({tag, ".wstrb"}, 32'(dmem_wstrb), 32'(expStrb));
                if (wen) checkOutput({tag, ".wdata"}, dmem_wdata, expData);
                checkOutput({tag, ".busy_ready_last"}, 32'(ready_last), 32'd0);
                checkOutput({tag, ".early_valid"}, 32'(valid_next), 32'd0);
                if (i == dlyReady) dmem_ready = 1'b1;
                else begin dmem_rvalid = 1'($urandom); dmem_rdata = $urandom; end
                @(posedge clock);
                @(negedge clock);
                dmem_ready  = 1'b0;
                dmem_rvalid = 1'b0;
            end
            for (int i = 0; i <= dlyRvalid; i++) begin
                checkOutput({tag, ".wait_req"}, 32'(dmem_req), 32'd0);
                checkOutput({tag, ".wait_valid"}, 32'(valid_next), 32'd0);
                checkOutput({tag, ".wait_ready_last"}, 32'(ready_last), 32'd0);
                if (i == dlyRvalid) begin dmem_rvalid = 1'b1; dmem_rdata = rdata; end
                else dmem_ready = 1'($urandom);
                @(posedge clock);
                @(negedge clock);
                dmem_ready  = 1'b0;
                dmem_rvalid = 1'b0;
                dmem_rdata  = $urandom;
            end
        end

        for (int i = 0; i <= dlyNext; i++) begin
            checkOutput({tag, ".valid_next"}, 32'(valid_next), 32'd1);
            checkOutput({tag, ".out_req"}, 32'(dmem_req), 32'd0);
            if (!misal) checkOutput({tag, ".wb_value"}, wb_value, expWb);
            checkOutput({tag, ".rd_next"}, 32'(rd_next), 32'(rdi));
            checkOutput({tag, ".R_wen_next"}, 32'(R_wen_next), 32'(expRw));
            checkOutput({tag, ".pc_out"}, pc_out, pcv);
            checkOutput({tag, ".misalign_err"}, 32'(misalign_err), 32'(misal && i == 0));
            checkOutput({tag, ".out_ready_last"}, 32'(ready_last), 32'd0);
            if (i == dlyNext) ready_next = 1'b1;
            else begin dmem_rvalid = 1'($urandom); dmem_rdata = $urandom; end
            @(posedge clock);
            @(negedge clock);
            ready_next  = 1'b0;
            dmem_rvalid = 1'b0;
        end
        checkOutput({tag, ".done_valid"}, 32'(valid_next), 32'd0);
        checkOutput({tag, ".done_ready_last"}, 32'(ready_last), 32'd1);
        checkOutput({tag, ".done_misalign"}, 32'(misalign_err), 32'd0);
    endtask

    initial begin
        logic [2:0] ldF3 [5];
        ldF3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        $display("[TB] starting mem_access_unit bench, misalign check %0d", ChkEn);
        #12;
        checkResetValues("reset");
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        applyStimulus("alu", 32'h1234, 32'h0, 32'h0, 3'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0,
                      32'h100, 32'h0, 0, 0, 0);
        applyStimulus("jal", 32'h5555, 32'h0, 32'h104, 3'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1,
                      32'h100, 32'h0, 0, 0, 1);
        applyStimulus("sb", 32'h1003, 32'hAB, 32'h0, 3'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0,
                      32'h200, 32'h0, 0, 0, 0);
        applyStimulus("lb", 32'h2002, 32'h0, 32'h0, 3'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0,
                      32'h204, 32'h0080_0000, 0, 0, 0);
        checkOutput("lb.const", expLoad(32'h0080_0000, 3'd0, 2'd2), 32'hFFFFFF80);
        applyStimulus("lhu", 32'h2002, 32'h0, 32'h0, 3'd5, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0,
                      32'h208, 32'h8001_0000, 0, 0, 0);
        checkOutput("lhu.const", expLoad(32'h8001_0000, 3'd5, 2'd2), 32'h00008001);
        applyStimulus("stall", 32'h2000, 32'h0, 32'h0, 3'd2, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0,
                      32'h20C, 32'hCAFE_F00D, 5, 2, 3);
        applyStimulus("sh_both", 32'h2006, 32'h1234_BEEF, 32'h0, 3'd1, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0,
                      32'h210, 32'h0, 1, 1, 0);
        applyStimulus("lw_mis", 32'h3002, 32'h0, 32'h0, 3'd2, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0,
                      32'h214, 32'h1357_9BDF, 0, 0, 1);

        // Reset while requesting must drop dmem_req immediately
        EX_result = 32'h4000; funct3 = 3'd2; mem_ren = 1'b1; mem_wen = 1'b0; valid_last = 1'b1;
        @(posedge clock);
        @(negedge clock);
        valid_last = 1'b0;
        checkOutput("rst_req.before", 32'(dmem_req), 32'd1);
        #1 reset = 1'b0;
        #1 checkOutput("rst_req.drop", 32'(dmem_req), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Reset while waiting for the response, then a stale response
        EX_result = 32'h4004; funct3 = 3'd2; mem_ren = 1'b1; mem_wen = 1'b0; R_wen = 1'b1;
        rd = 5'd10; pc = 32'h300; valid_last = 1'b1;
        @(posedge clock);
        @(negedge clock);
        valid_last = 1'b0;
        dmem_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        dmem_ready = 1'b0;
        reset = 1'b0;
        #1 checkResetValues("rst_wait");
        @(negedge clock);
        reset = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        @(posedge clock);
        @(negedge clock);
        dmem_rvalid = 1'b0;
        checkResetValues("stale_rvalid");
        applyStimulus("post_rst", 32'h4008, 32'h0, 32'h0, 3'd4, 5'd11, 1'b1, 1'b0, 1'b1, 1'b0,
                      32'h304, 32'h00FF_7F00, 1, 1, 1);

        for (int n = 0; n < 60; n++) begin
            int kind;
            logic [2:0] f3;
            logic wen, ren, jmp;
            kind = int'($urandom_range(0, 3));
            jmp = 1'b0; wen = 1'b0; ren = 1'b0;
            f3 = 3'($urandom);
            case (kind)
                0: ;
                1: jmp = 1'b1;
                2: begin ren = 1'b1; f3 = ldF3[$urandom_range(0, 4)]; end
                default: begin wen = 1'b1; ren = 1'($urandom); f3 = 3'($urandom_range(0, 2)); end
            endcase
            applyStimulus($sformatf("rnd%0d", n), $urandom, $urandom, $urandom, f3, 5'($urandom),
                          1'($urandom), wen, ren, jmp, $urandom, $urandom, 
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
